// File: rtl/asteroid_collision.sv
// asteroid_collision: sequential ship/asteroid bounding-box overlap scanner.
// On a start request the ship and all eight asteroid corners are snapshotted,
// then one asteroid is tested per cycle (lowest index first). The first hit
// ends the scan early; a one-cycle REPORT state pulses oDone (and oCollision
// when a hit was found) before returning to IDLE.
module asteroid_collision #(
    parameter logic [7:0] SHIP_W = 8'd8,
    parameter logic [6:0] SHIP_H = 7'd8,
    parameter logic [7:0] AST_W  = 8'd6,
    parameter logic [6:0] AST_H  = 7'd6
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iStart,
    input  logic [7:0] iShipX,
    input  logic [6:0] iShipY,
    input  logic [7:0] iX1,
    input  logic [7:0] iX2,
    input  logic [7:0] iX3,
    input  logic [7:0] iX4,
    input  logic [7:0] iX5,
    input  logic [7:0] iX6,
    input  logic [7:0] iX7,
    input  logic [7:0] iX8,
    input  logic [6:0] iY1,
    input  logic [6:0] iY2,
    input  logic [6:0] iY3,
    input  logic [6:0] iY4,
    input  logic [6:0] iY5,
    input  logic [6:0] iY6,
    input  logic [6:0] iY7,
    input  logic [6:0] iY8,
    output logic       oCollision,
    output logic [2:0] oHitIndex,
    output logic       oBusy,
    output logic       oDone
);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic            hit_q, hit_d;
    logic [2:0]      hit_idx_q, hit_idx_d;
    logic [7:0]      ship_x_q, ship_x_d;
    logic [6:0]      ship_y_q, ship_y_d;
    logic [7:0][7:0] ax_q, ax_d;
    logic [7:0][6:0] ay_q, ay_d;

    // Element 0 is asteroid 1, so the scan index equals the reported index.
    logic [7:0][7:0] in_x;
    logic [7:0][6:0] in_y;
    assign in_x = {iX8, iX7, iX6, iX5, iX4, iX3, iX2, iX1};
    assign in_y = {iY8, iY7, iY6, iY5, iY4, iY3, iY2, iY1};

    // Overlap test for the asteroid selected by the scan index. Sums are one
    // bit wider than the coordinates so an asteroid parked at X=160 (or any
    // right-edge position) is compared literally without wrap.
    logic [8:0] sx9, ax9;
    logic [7:0] sy8, ay8;
    logic       overlap;
    always_comb begin
        sx9     = {1'b0, ship_x_q};
        ax9     = {1'b0, ax_q[idx_q]};
        sy8     = {1'b0, ship_y_q};
        ay8     = {1'b0, ay_q[idx_q]};
        overlap = (sx9 < ax9 + {1'b0, AST_W})  && (ax9 < sx9 + {1'b0, SHIP_W}) &&
                  (sy8 < ay8 + {1'b0, AST_H})  && (ay8 < sy8 + {1'b0, SHIP_H});
    end

    // Next-state logic: snapshot on start, walk indices, stop on first hit.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hit_d     = hit_q;
        hit_idx_d = hit_idx_q;
        ship_x_d  = ship_x_q;
        ship_y_d  = ship_y_q;
        ax_d      = ax_q;
        ay_d      = ay_q;
        unique case (state_q)
            IDLE: begin
                if (iStart) begin
                    ship_x_d = iShipX;
                    ship_y_d = iShipY;
                    ax_d     = in_x;
                    ay_d     = in_y;
                    hit_d    = 1'b0;
                    idx_d    = 3'd0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if (overlap) begin
                    hit_d     = 1'b1;
                    hit_idx_d = idx_q;
                    state_d   = REPORT;
                end else if (idx_q == 3'd7) begin
                    state_d = REPORT;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and snapshot registers; reset clears everything immediately.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            hit_q     <= 1'b0;
            hit_idx_q <= 3'd0;
            ship_x_q  <= 8'd0;
            ship_y_q  <= 7'd0;
            ax_q      <= '0;
            ay_q      <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hit_q     <= hit_d;
            hit_idx_q <= hit_idx_d;
            ship_x_q  <= ship_x_d;
            ship_y_q  <= ship_y_d;
            ax_q      <= ax_d;
            ay_q      <= ay_d;
        end
    end

    // Moore-decoded outputs so an async reset drops them at once.
    always_comb begin
        oBusy      = (state_q != IDLE);
        oDone      = (state_q == REPORT);
        oCollision = (state_q == REPORT) && hit_q;
        oHitIndex  = hit_idx_q;
    end

endmodule

// File: tb/tb_asteroid_collision.sv
// Directed bench for asteroid_collision: reset state, no-hit and hit scans,
// strict-overlap edges, lowest-index priority, mid-scan reset, held start.
module tb_asteroid_collision;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       iStart;
    logic [7:0] iShipX;
    logic [6:0] iShipY;
    logic [7:0] ax [8];
    logic [6:0] ay [8];
    logic       oCollision;
    logic [2:0] oHitIndex;
    logic       oBusy;
    logic       oDone;

    int tests = 0;
    int fails = 0;

    asteroid_collision dut (
        .Clock(Clock), .Reset(Reset), .iStart(iStart),
        .iShipX(iShipX), .iShipY(iShipY),
        .iX1(ax[0]), .iX2(ax[1]), .iX3(ax[2]), .iX4(ax[3]),
        .iX5(ax[4]), .iX6(ax[5]), .iX7(ax[6]), .iX8(ax[7]),
        .iY1(ay[0]), .iY2(ay[1]), .iY3(ay[2]), .iY4(ay[3]),
        .iY5(ay[4]), .iY6(ay[5]), .iY7(ay[6]), .iY8(ay[7]),
        .oCollision(oCollision), .oHitIndex(oHitIndex),
        .oBusy(oBusy), .oDone(oDone)
    );

    always #5 Clock = ~Clock;

    task automatic far_all();
        for (int i = 0; i < 8; i++) begin
            ax[i] = 8'd200;
            ay[i] = 7'd0;
        end
    endtask

    task automatic no_hit_setup();
        iShipX = 8'd100;
        iShipY = 7'd100;
        for (int i = 0; i < 8; i++) begin
            ax[i] = 8'(10 * i);
            ay[i] = 7'(20 + 10 * i);
        end
    endtask

    // Called at 1 time unit after an edge. Raises iStart for one edge (N),
    // then observes cycles after N+0 .. N+19. done_at = k of first oDone.
    task automatic run_scan(output int done_at, output int busy_cnt,
                            output int coll_cnt, output logic coll_at_done);
        done_at = -1; busy_cnt = 0; coll_cnt = 0; coll_at_done = 1'b0;
        iStart = 1'b1;
        @(posedge Clock); #1;
        iStart = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (oBusy) busy_cnt++;
            if (oDone && done_at < 0) begin
                done_at = k;
                coll_at_done = oCollision;
            end
            if (oCollision) coll_cnt++;
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0; iStart = 1'b0; iShipX = '0; iShipY = '0;
        for (int i = 0; i < 8; i++) begin ax[i] = '0; ay[i] = '0; end
        #3;
        tests++; if (oBusy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", oBusy); end
        tests++; if (oDone !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", oDone); end
        tests++; if (oCollision !== 1'b0) begin fails++; $display("FAIL reset_coll got=%b exp=0", oCollision); end
        tests++; if (oHitIndex !== 3'd0) begin fails++; $display("FAIL reset_idx got=%0d exp=0", oHitIndex); end
        @(posedge Clock); @(posedge Clock); #1;
        Reset = 1'b1;
        @(posedge Clock); #1;
    endtask

    task automatic test_no_hit();
        int d, b, c; logic cd;
        no_hit_setup();
        run_scan(d, b, c, cd);
        tests++; if (d !== 8) begin fails++; $display("FAIL nohit_done_at got=%0d exp=8", d); end
        tests++; if (b !== 9) begin fails++; $display("FAIL nohit_busy_cycles got=%0d exp=9", b); end
        tests++; if (cd !== 1'b0 || c !== 0) begin fails++; $display("FAIL nohit_coll got=%b/%0d exp=0/0", cd, c); end
        tests++; if (oHitIndex !== 3'd0) begin fails++; $display("FAIL nohit_idx got=%0d exp=0", oHitIndex); end
    endtask

    task automatic test_single_hit();
        int d, b, c; logic cd;
        far_all();
        iShipX = 8'd30; iShipY = 7'd50;
        ax[3] = 8'd30; ay[3] = 7'd50;
        run_scan(d, b, c, cd);
        tests++; if (d !== 4) begin fails++; $display("FAIL hit3_done_at got=%0d exp=4", d); end
        tests++; if (cd !== 1'b1 || c !== 1) begin fails++; $display("FAIL hit3_coll got=%b/%0d exp=1/1", cd, c); end
        tests++; if (oHitIndex !== 3'd3) begin fails++; $display("FAIL hit3_idx got=%0d exp=3", oHitIndex); end
        tests++; if (b !== 5) begin fails++; $display("FAIL hit3_busy_cycles got=%0d exp=5", b); end
    endtask

    task automatic test_edges();
        int d, b, c; logic cd;
        // touching right edge: 58 < 50+8 is false -> no hit, index kept at 3
        far_all();
        iShipX = 8'd50; iShipY = 7'd60;
        ax[4] = 8'd58; ay[4] = 7'd60;
        run_scan(d, b, c, cd);
        tests++; if (d !== 8 || cd !== 1'b0) begin fails++; $display("FAIL edge58 got=done%0d/coll%b exp=done8/coll0", d, cd); end
        tests++; if (oHitIndex !== 3'd3) begin fails++; $display("FAIL edge58_idx_hold got=%0d exp=3", oHitIndex); end
        // one pixel in -> hit at index 4
        ax[4] = 8'd57;
        run_scan(d, b, c, cd);
        tests++; if (d !== 5 || cd !== 1'b1) begin fails++; $display("FAIL edge57 got=done%0d/coll%b exp=done5/coll1", d, cd); end
        tests++; if (oHitIndex !== 3'd4) begin fails++; $display("FAIL edge57_idx got=%0d exp=4", oHitIndex); end
        // asteroid at X=160 compared literally against ship at 155
        far_all();
        iShipX = 8'd155; iShipY = 7'd40;
        ax[0] = 8'd160; ay[0] = 7'd40;
        run_scan(d, b, c, cd);
        tests++; if (d !== 1 || cd !== 1'b1) begin fails++; $display("FAIL x160 got=done%0d/coll%b exp=done1/coll1", d, cd); end
        tests++; if (oHitIndex !== 3'd0) begin fails++; $display("FAIL x160_idx got=%0d exp=0", oHitIndex); end
    endtask

    task automatic test_priority();
        int d, b, c; logic cd;
        far_all();
        iShipX = 8'd30; iShipY = 7'd50;
        ax[1] = 8'd32; ay[1] = 7'd52;
        ax[5] = 8'd32; ay[5] = 7'd52;
        run_scan(d, b, c, cd);
        tests++; if (d !== 2) begin fails++; $display("FAIL prio_done_at got=%0d exp=2", d); end
        tests++; if (oHitIndex !== 3'd1) begin fails++; $display("FAIL prio_idx got=%0d exp=1", oHitIndex); end
        tests++; if (c !== 1) begin fails++; $display("FAIL prio_pulses got=%0d exp=1", c); end
    endtask

    task automatic test_reset_mid();
        int d, b, c; logic cd; int bad;
        no_hit_setup();
        iStart = 1'b1;
        @(posedge Clock); #1;
        iStart = 1'b0;
        for (int k = 0; k < 3; k++) begin @(posedge Clock); #1; end
        #2 Reset = 1'b0;
        #1;
        tests++; if (oBusy !== 1'b0 || oDone !== 1'b0 || oCollision !== 1'b0) begin
            fails++; $display("FAIL midrst_outs got=b%b d%b c%b exp=000", oBusy, oDone, oCollision); end
        tests++; if (oHitIndex !== 3'd0) begin fails++; $display("FAIL midrst_idx got=%0d exp=0", oHitIndex); end
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge Clock); #1;
            if (oBusy || oDone || oCollision) bad++;
        end
        Reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge Clock); #1;
            if (oBusy || oDone || oCollision) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL midrst_no_pulse got=%0d exp=0", bad); end
        far_all();
        iShipX = 8'd30; iShipY = 7'd50;
        ax[3] = 8'd30; ay[3] = 7'd50;
        run_scan(d, b, c, cd);
        tests++; if (d !== 4 || cd !== 1'b1 || oHitIndex !== 3'd3) begin
            fails++; $display("FAIL midrst_rescan got=done%0d/coll%b/idx%0d exp=done4/coll1/idx3", d, cd, oHitIndex); end
    endtask

    task automatic test_back_to_back();
        int dq[$]; int c;
        c = 0;
        no_hit_setup();
        iStart = 1'b1;
        @(posedge Clock); #1;
        for (int k = 0; k < 30; k++) begin
            if (oDone) dq.push_back(k);
            if (oCollision) c++;
            if (k == 3) begin ax[2] = 8'd100; ay[2] = 7'd100; end
            if (k == 5) begin ax[2] = 8'd20;  ay[2] = 7'd40;  end
            @(posedge Clock); #1;
        end
        iStart = 1'b0;
        for (int k = 0; k < 12; k++) begin @(posedge Clock); #1; end
        tests++; if (dq.size() !== 3) begin fails++; $display("FAIL b2b_pulses got=%0d exp=3", dq.size()); end
        else begin
            tests++; if (dq[0] !== 8 || dq[1] !== 18 || dq[2] !== 28) begin
                fails++; $display("FAIL b2b_period got=%0d,%0d,%0d exp=8,18,28", dq[0], dq[1], dq[2]); end
        end
        tests++; if (c !== 0) begin fails++; $display("FAIL b2b_coll got=%0d exp=0", c); end
    endtask

    initial begin
        test_reset();
        test_no_hit();
        test_single_hit();
        test_edges();
        test_priority();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
